gpr_dump_reader: RTL and testbench

Debug read-out engine for the 8×16 general-purpose register file. On a start pulse it walks one register-file read port through addresses 0..7 and captures each value. It streams each value out over a valid/ready handshake, then sends a 16-bit wrap-around checksum beat. It sits beside the register file, sharing a read-address port with the debug/trace path, and never drives the register file's write port.

---
 rtl/gpr_dump_reader_if.sv | 23 ++
 rtl/gpr_dump_reader.sv | 125 ++++++++++++
 tb/tb_gpr_dump_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_dump_reader_if.sv
// Output stream of the register dump: one beat per register value, then a checksum beat.
// valid/ready: a beat transfers on a rising edge where out_valid && out_ready; once raised, out_valid and the payload hold until that edge.
interface gpr_dump_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_is_sum;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_index, out_is_sum, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_is_sum, out_last,
    output out_ready
  );
endinterface

// File: rtl/gpr_dump_reader.sv
// Debug dump engine: walks the register-file read port over every address, streams each value,
// then streams a 16-bit wrap-around checksum of the values sent.
module gpr_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  gpr_dump_reader_if.master    out_if,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    SUM  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] sum, sum_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic [ADDR_W-1:0] index_q, index_nx;
  logic              valid_q, valid_nx;
  logic              is_sum_q, is_sum_nx;
  logic              done_q, done_nx;
  logic              hs;

  assign hs = valid_q && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      sum      <= '0;
      data_q   <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      is_sum_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      sum      <= sum_nx;
      data_q   <= data_nx;
      index_q  <= index_nx;
      valid_q  <= valid_nx;
      is_sum_q <= is_sum_nx;
      done_q   <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    sum_nx    = sum;
    data_nx   = data_q;
    index_nx  = index_q;
    valid_nx  = valid_q;
    is_sum_nx = is_sum_q;
    done_nx   = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = READ;
          idx_nx   = '0;
          sum_nx   = '0;
        end
      end
      READ: begin
        // rd_data is combinational from rd_addr, so the value is captured in this same cycle.
        rd_addr  = idx;
        data_nx  = rd_data;
        index_nx = idx;
        sum_nx   = sum + rd_data;
        valid_nx = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            data_nx   = sum;
            is_sum_nx = 1'b1;
            index_nx  = '0;
            valid_nx  = 1'b1;
            state_nx  = SUM;
          end else begin
            idx_nx   = idx + ADDR_W'(1);
            valid_nx = 1'b0;
            state_nx = READ;
          end
        end
      end
      SUM: begin
        if (hs) begin
          valid_nx  = 1'b0;
          is_sum_nx = 1'b0;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy              = (state != IDLE);
  assign done              = done_q;
  assign dbg_state         = state;
  assign out_if.out_valid  = valid_q;
  assign out_if.out_data   = data_q;
  assign out_if.out_index  = index_q;
  assign out_if.out_is_sum = is_sum_q;
  assign out_if.out_last   = is_sum_q;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Bench for gpr_dump_reader: a register-file array feeds the read port, drivers run dump scenarios,
// and a negedge compare process checks every output against a beat-list model.
module tb_gpr_dump_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  dbg_state;

  logic [15:0] regs [8];
  logic [15:0] plan [8];

  gpr_dump_reader_if #(.ADDR_W(3), .DATA_W(16)) sink ();

  gpr_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_if    (sink),
    .dbg_state (dbg_state)
  );

  assign rd_data = regs[rd_addr];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink: ready tied high, or about 30% duty when stalling.
  initial sink.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    sink.out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
  end

  // ---------------- scoreboard / model ----------------
  logic [19:0] exp_q [$];
  logic        in_dump   = 1'b0;
  logic        exp_done  = 1'b0;
  logic        prev_rst  = 1'b1;
  logic        prev_pend = 1'b0;
  logic [19:0] prev_beat = '0;
  logic        tied      = 1'b0;
  int          cyc       = 0;
  int          start_cyc = 0;
  int          beat_cnt  = 0;

  always @(negedge clk) begin
    logic        hs;
    logic        nx_in_dump;
    logic        nx_done;
    logic [19:0] beat;
    beat = {sink.out_data, sink.out_index, sink.out_is_sum};
    if (prev_rst) begin
      check("rst_valid",  sink.out_valid,  1'b0);
      check("rst_data",   sink.out_data,   16'h0);
      check("rst_index",  sink.out_index,  3'd0);
      check("rst_is_sum", sink.out_is_sum, 1'b0);
      check("rst_last",   sink.out_last,   1'b0);
      check("rst_busy",   busy,            1'b0);
      check("rst_done",   done,            1'b0);
      check("rst_rd_addr", rd_addr,        3'd0);
      check("rst_state",  dbg_state,       2'd0);
    end else begin
      check("busy", busy, in_dump);
      check("done", done, exp_done);
      check("last_eq_sum", sink.out_last, sink.out_is_sum);
      if (!in_dump) begin
        check("idle_valid", sink.out_valid, 1'b0);
        check("idle_rd_addr", rd_addr, 3'd0);
      end
      if (prev_pend) begin
        check("stall_valid", sink.out_valid, 1'b1);
        check("stall_payload", beat, prev_beat);
      end
    end

    hs         = sink.out_valid && sink.out_ready && reset;
    nx_in_dump = in_dump;
    nx_done    = 1'b0;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", beat, 20'h0);
      end else begin
        check("beat", beat, exp_q.pop_front());
      end
      beat_cnt++;
      if (sink.out_is_sum) begin
        check("beat_count", beat_cnt, 9);
        if (tied) check("dump_latency", cyc - start_cyc, 17);
        nx_in_dump = 1'b0;
        nx_done    = 1'b1;
      end
    end
    if (reset && start && !in_dump) begin
      nx_in_dump = 1'b1;
      start_cyc  = cyc;
      beat_cnt   = 0;
      tied       = (rdy_mode == 0);
    end
    prev_pend = sink.out_valid && !hs && reset;
    prev_beat = beat;
    in_dump   = nx_in_dump;
    exp_done  = nx_done;
    if (!reset) begin
      exp_q.delete();
      in_dump   = 1'b0;
      exp_done  = 1'b0;
      prev_pend = 1'b0;
    end
    prev_rst = !reset;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(output logic [15:0] total);
    total = '0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({plan[i], 3'(i), 1'b0});
      total = total + plan[i];
    end
    exp_q.push_back({total, 3'd0, 1'b1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("done_timeout", found, 1'b1);
  endtask

  task automatic wait_beat(input logic [2:0] idx);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (sink.out_valid && sink.out_index == idx && !sink.out_is_sum) found = 1'b1;
    end
    check("beat_wait_timeout", found, 1'b1);
  endtask

  task automatic load_seq();
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'(i + 1);
      plan[i] = regs[i];
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'($urandom);
      plan[i] = regs[i];
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [15:0] total;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Normal dump, ready tied high.
    rdy_mode = 0;
    load_seq();
    push_expected(total);
    check("pin_sum_seq", exp_q[exp_q.size() - 1], {16'h0024, 3'd0, 1'b1});
    pulse_start();
    wait_done(100);
    repeat (2) tick();

    // Wrap-around checksum.
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'hFFFF;
      plan[i] = regs[i];
    end
    push_expected(total);
    check("pin_sum_wrap", total, 16'hFFF8);
    pulse_start();
    wait_done(100);
    repeat (2) tick();

    // Backpressure with random ready.
    rdy_mode = 1;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) load_seq();
      else load_rand();
      push_expected(total);
      pulse_start();
      wait_done(600);
      tick();
    end
    rdy_mode = 0;
    repeat (2) tick();

    // Start while busy is ignored; start on the done cycle launches a new dump.
    load_rand();
    push_expected(total);
    pulse_start();
    repeat ($urandom_range(2, 10)) tick();
    pulse_start();
    wait_done(100);
    push_expected(total);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    repeat (2) tick();

    // Reset during the R3 beat aborts the dump.
    load_rand();
    push_expected(total);
    pulse_start();
    wait_beat(3'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    push_expected(total);
    pulse_start();
    wait_done(100);
    repeat (2) tick();

    // Write R5 while beat R2 is on the bus; the dump sees the new value.
    rdy_mode = 1;
    load_rand();
    plan[5] = 16'hABCD;
    push_expected(total);
    pulse_start();
    wait_beat(3'd2);
    regs[5] = 16'hABCD;
    wait_done(600);
    rdy_mode = 0;
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
